// File: rtl/mcycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB state machine with handshaked memories.
// Latency (zero wait states): j 2, beq/bne 3, R-type/addi/sw 4, lw 5 cycles; each wait cycle adds 1.
// Backpressure: inst_req/mem_read/mem_write are held with stable address/data until the ready input is sampled high.
// Optional feature macro: MCPU_BNE_EN (decodes opcode 05 as bne; otherwise opcode 05 is illegal).
module mcycle_cpu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HALT_ADDR  = 32'hFFFF_FFFF,
    parameter logic [5:0]  HALT_FUNCT = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    output logic        inst_req,
    input  logic [31:0] instr,
    input  logic        inst_ready,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] data_out,
    input  logic        data_ready,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t      state, state_nxt;
    logic [31:0] pc, pc4, ir, a_q, b_q, alu_q, mdr_q;
    logic        err_q;
    logic [31:0] regs [32];

    // Instruction fields come straight from the latched IR.
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext;
    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};

    logic is_halt, is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_legal;
    assign is_halt  = (op == OP_RTYPE) && (funct == HALT_FUNCT);
    assign is_rtype = (op == OP_RTYPE) && !is_halt &&
                      (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                       funct == FN_OR  || funct == FN_SLT);
    assign is_addi  = (op == OP_ADDI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
`ifdef MCPU_BNE_EN
    assign is_bne   = (op == OP_BNE);
`else
    assign is_bne   = 1'b0;
`endif
    assign is_legal = is_halt || is_rtype || is_addi || is_lw || is_sw ||
                      is_beq || is_bne || is_j;

    // ALU: R-type uses B, everything else adds the sign-extended immediate.
    logic [31:0] alu_b, alu_res, br_target;
    logic        br_taken;
    assign alu_b     = is_rtype ? b_q : sext;
    assign br_target = pc4 + (sext << 2);
    assign br_taken  = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

    // ALU operation select.
    always_comb begin
        alu_res = a_q + alu_b;
        if (is_rtype) begin
            case (funct)
                FN_SUB:  alu_res = a_q - alu_b;
                FN_AND:  alu_res = a_q & alu_b;
                FN_OR:   alu_res = a_q | alu_b;
                FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
                default: alu_res = a_q + alu_b;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded request outputs.
    always_comb begin
        state_nxt = state;
        inst_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                inst_req = 1'b1;
                if (inst_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_j)                      state_nxt = S_FETCH;
                else if (is_halt || !is_legal) state_nxt = S_HALT;
                else                           state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_beq || is_bne)   state_nxt = S_FETCH;
                else if (is_lw || is_sw) state_nxt = S_MEM;
                else                     state_nxt = S_WB;
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
                if (data_ready) state_nxt = is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: IR/PC4 on fetch, A/B and jump on decode, ALUOut/PC on exec, MDR on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            pc4   <= RESET_PC;
            ir    <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            alu_q <= 32'd0;
            mdr_q <= 32'd0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (inst_ready) begin
                        ir  <= instr;
                        pc4 <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_q <= regs[rs];
                    b_q <= regs[rt];
                    if (is_j)      pc    <= {pc4[31:28], ir[25:0], 2'b00};
                    if (!is_legal) err_q <= 1'b1;
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    pc    <= br_taken ? br_target : pc4;
                end
                S_MEM: begin
                    if (is_lw && data_ready) mdr_q <= data_out;
                end
                default: ;
            endcase
        end
    end

    // Register file write port; $0 is never written so it always reads zero.
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    assign wb_addr = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr_q : alu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (state == S_WB && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign inst_addr = (state == S_HALT) ? HALT_ADDR : pc;
    assign data_addr = alu_q;
    assign data_in   = b_q;
    assign halted    = (state == S_HALT) && !err_q;
    assign err       = (state == S_HALT) && err_q;

endmodule

// File: tb/tb_mcycle_cpu.sv
// Testbench for mcycle_cpu: ordered instruction feed, data-memory responder, store scoreboard.
// Latency is checked fetch-to-fetch; wait states are injected on both memory ports.
// Bounded waits everywhere; a global time limit ends the run with a FAIL line.
module tb_mcycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr, data_addr, data_in;
    logic        inst_req, mem_read, mem_write, halted, err;
    logic [31:0] instr = 32'd0;
    logic        inst_ready = 1'b0;
    logic [31:0] data_out = 32'hDEAD_BEEF;
    logic        data_ready = 1'b0;

    mcycle_cpu dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_req(inst_req), .instr(instr), .inst_ready(inst_ready),
        .data_addr(data_addr), .data_in(data_in), .mem_read(mem_read), .mem_write(mem_write),
        .data_out(data_out), .data_ready(data_ready), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pend_lat = -1;
    int start_cyc = 0;
    int data_wait = 0;
    int req_cycles = 0;
    int last_len = 0;
    logic [31:0] st_addr_q[$];
    logic [31:0] st_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Data memory: grants after data_wait request cycles; stores are checked against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mem_read || mem_write) begin
            if (req_cycles == data_wait) begin
                data_ready = 1'b1;
                if (mem_write) begin
                    if (st_addr_q.size() == 0) begin
                        check_val("store_unexpected", 32'd1, 32'd0);
                    end else begin
                        check_val("store_addr", data_addr, st_addr_q.pop_front());
                        check_val("store_data", data_in, st_data_q.pop_front());
                    end
                end
            end
            req_cycles++;
        end else begin
            if (req_cycles > 0) last_len = req_cycles;
            req_cycles = 0;
            data_ready = 1'b0;
        end
    end

    // Waits for a fetch request, checks its address and the previous instruction's
    // latency, then supplies ins after iwait extra cycles. Returns at the DECODE negedge.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] ins,
                         input int iwait, input int lat);
        int n = 0;
        while (!inst_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inst_req) begin
            check_val("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        if (pend_lat >= 0) check_val("latency", 32'(cyc - start_cyc), 32'(pend_lat));
        check_val("fetch_addr", inst_addr, exp_addr);
        start_cyc = cyc;
        pend_lat  = lat;
        repeat (iwait) @(negedge clk);
        instr      = ins;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        instr      = 32'hBAD0_BAD0;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        st_addr_q.push_back(a);
        st_data_q.push_back(d);
    endtask

    initial begin
        int n;
        int req_seen;
        repeat (2) @(negedge clk);
        check_val("rst_inst_addr", inst_addr, 32'h0000_3000);
        check_val("rst_inst_req", {31'd0, inst_req}, 32'd0);
        check_val("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("rst_status", {30'd0, halted, err}, 32'd0);
        check_val("rst_data_addr", data_addr, 32'd0);
        check_val("rst_data_in", data_in, 32'd0);
        rst = 1'b0;

        fetch(32'h3000, 32'h2001_0005, 0, 4);            // addi $1,$0,5
        fetch(32'h3004, 32'h2002_0007, 0, 4);            // addi $2,$0,7
        fetch(32'h3008, 32'h0022_1820, 0, 4);            // add $3,$1,$2
        expect_store(32'd0, 32'd12);
        fetch(32'h300C, 32'hAC03_0000, 0, 4);            // sw $3,0($0)
        fetch(32'h3010, 32'h1021_FFFF, 0, 3);            // beq $1,$1,-1 (taken)
        check_val("sw_pulse_len", 32'(last_len), 32'd1);
        fetch(32'h3010, 32'h1022_0000, 0, 3);            // beq $1,$2,0 (not taken)
        fetch(32'h3014, 32'h0800_0100, 0, 2);            // j 0x100
        data_wait = 3;
        fetch(32'h0400, 32'h8C04_0000, 0, 8);            // lw $4,0($0), 3 wait states
        expect_store(32'd4, 32'hDEAD_BEEF);
        fetch(32'h0404, 32'hAC04_0004, 0, 4);            // sw $4,4($0)
        check_val("lw_read_len", 32'(last_len), 32'd4);
        data_wait = 0;
        fetch(32'h0408, 32'h0022_3022, 2, 6);            // sub $6,$1,$2, 2 fetch waits
        expect_store(32'd8, 32'hFFFF_FFFE);
        fetch(32'h040C, 32'hAC06_0008, 0, 4);            // sw $6,8($0)
        fetch(32'h0410, 32'h00C1_382A, 0, 4);            // slt $7,$6,$1
        expect_store(32'd12, 32'd1);
        fetch(32'h0414, 32'hAC07_000C, 0, 4);            // sw $7,12($0)
        fetch(32'h0418, 32'h0022_4024, 0, 4);            // and $8,$1,$2
        expect_store(32'd16, 32'd5);
        fetch(32'h041C, 32'hAC08_0010, 0, 4);            // sw $8,16($0)
        fetch(32'h0420, 32'h0022_4825, 0, 4);            // or $9,$1,$2
        expect_store(32'd20, 32'd7);
        fetch(32'h0424, 32'hAC09_0014, 0, 4);            // sw $9,20($0)
        fetch(32'h0428, 32'h0000_003F, 0, -1);           // halt
        @(negedge clk);
        check_val("halt_status", {30'd0, halted, err}, 32'h2);
        check_val("halt_addr", inst_addr, 32'hFFFF_FFFF);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            inst_ready = ~inst_ready;
            @(negedge clk);
            if (inst_req || mem_read || mem_write) req_seen++;
        end
        inst_ready = 1'b0;
        check_val("halt_no_req", 32'(req_seen), 32'd0);
        check_val("halt_addr_hold", inst_addr, 32'hFFFF_FFFF);

        // Reset restart, then reset during a stalled load.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend_lat = -1;
        fetch(32'h3000, 32'h2002_0009, 0, 4);            // addi $2,$0,9
        data_wait = 1000;
        fetch(32'h3004, 32'h8C02_0000, 0, -1);           // lw $2,0($0), stalled
        n = 0;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("stall_mem_read", {31'd0, mem_read}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_drop_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("rst_mid_addr", inst_addr, 32'h0000_3000);
        @(negedge clk);
        rst = 1'b0;
        data_wait = 0;
        pend_lat = -1;
        expect_store(32'd0, 32'd0);
        fetch(32'h3000, 32'hAC02_0000, 0, 4);            // sw $2,0($0): $2 still 0
`ifdef MCPU_BNE_EN
        fetch(32'h3004, 32'h2001_0001, 0, 4);            // addi $1,$0,1
        fetch(32'h3008, 32'h1420_FFFF, 0, 3);            // bne $1,$0,-1 (taken)
        fetch(32'h3008, 32'h0000_003F, 0, -1);           // halt
        @(negedge clk);
        check_val("bne_halt_status", {30'd0, halted, err}, 32'h2);
`else
        fetch(32'h3004, 32'h1422_0000, 0, -1);           // opcode 05: illegal
        @(negedge clk);
        check_val("illegal_status", {30'd0, halted, err}, 32'h1);
        check_val("illegal_addr", inst_addr, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        check_val("illegal_no_req", {29'd0, inst_req, mem_read, mem_write}, 32'd0);
`endif
        check_val("store_queue_empty", 32'(st_addr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
